// File: rtl/combination_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : combination_entry                                               |
// | Purpose  : Debounced three-button entry of a four-digit hex combination,   |
// |            compared against CODE; drives display Select/Number, Unlocked.  |
// | Options  : LOCKOUT_EN - hold off further attempts after three fails.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module combination_entry #(
  parameter int          DWL             = 8,
  parameter logic [15:0] CODE            = 16'h1234,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          FAIL_HOLD       = 100000000,
  parameter int          LOCKOUT_CYCLES  = 500000000
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           BTN_UP,
  input  logic           BTN_DOWN,
  input  logic           BTN_ENTER,
  output logic [DWL-6:0] Select,
  output logic [DWL-5:0] Number,
  output logic           Unlocked
);

  localparam int c_db_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_tmax    = (FAIL_HOLD > LOCKOUT_CYCLES) ? FAIL_HOLD : LOCKOUT_CYCLES;
  localparam int c_timer_w = $clog2(c_tmax + 1);
  localparam int c_nw      = DWL - 4;
  localparam int c_sw      = DWL - 5;

  // State encodings double as the display Select codes.
  typedef enum logic [2:0] {
    S_LOCKED  = 3'b000,
    S_D0      = 3'b001,
    S_D1      = 3'b010,
    S_D2      = 3'b011,
    S_D3      = 3'b100,
    S_LOCKOUT = 3'b101,
    S_PASS    = 3'b110,
    S_FAIL    = 3'b111
  } state_t;

  logic [2:0] w_raw;
  logic [2:0] w_press;
  logic       w_up;
  logic       w_down;
  logic       w_enter;

  assign w_raw = {BTN_ENTER, BTN_DOWN, BTN_UP};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic [1:0]        r_sync;
    logic              r_level;
    logic              r_level_d;
    logic              r_press;
    logic [c_db_w-1:0] r_cnt;

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        r_sync    <= '0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_press   <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_sync    <= {r_sync[0], w_raw[gi]};
        r_level_d <= r_level;
        r_press   <= r_level & ~r_level_d;
        // Any sample agreeing with the accepted level restarts the count.
        if (r_sync[1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_db_w'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  assign w_up    = w_press[0] & ~w_press[1];
  assign w_down  = w_press[1] & ~w_press[0];
  assign w_enter = w_press[2];

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_nw-1:0]      r_number;
  logic [c_nw-1:0]      w_number_nxt;
  logic [11:0]          r_entry;
  logic [11:0]          w_entry_nxt;
  logic [c_timer_w-1:0] r_timer;
  logic [c_timer_w-1:0] w_timer_nxt;
  logic                 r_unlocked;
`ifdef LOCKOUT_EN
  logic [1:0]           r_fails;
  logic [1:0]           w_fails_nxt;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= S_LOCKED;
      r_number   <= '0;
      r_entry    <= '0;
      r_timer    <= '0;
      r_unlocked <= 1'b0;
`ifdef LOCKOUT_EN
      r_fails    <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_number   <= w_number_nxt;
      r_entry    <= w_entry_nxt;
      r_timer    <= w_timer_nxt;
      r_unlocked <= (w_state_nxt == S_PASS);
`ifdef LOCKOUT_EN
      r_fails    <= w_fails_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_number_nxt = r_number;
    w_entry_nxt  = r_entry;
    w_timer_nxt  = r_timer;
`ifdef LOCKOUT_EN
    w_fails_nxt  = r_fails;
`endif
    case (r_state)
      S_LOCKED: begin
        if (w_enter) w_state_nxt = S_D0;
      end
      S_D0, S_D1, S_D2, S_D3: begin
        if (w_enter) begin
          w_number_nxt = '0;
          case (r_state)
            S_D0: begin
              w_entry_nxt[11:8] = r_number[3:0];
              w_state_nxt       = S_D1;
            end
            S_D1: begin
              w_entry_nxt[7:4] = r_number[3:0];
              w_state_nxt      = S_D2;
            end
            S_D2: begin
              w_entry_nxt[3:0] = r_number[3:0];
              w_state_nxt      = S_D3;
            end
            default: begin
              // Last digit is compared straight from Number, not the entry register.
              w_timer_nxt = '0;
              if ({r_entry, r_number[3:0]} == CODE) begin
                w_state_nxt = S_PASS;
`ifdef LOCKOUT_EN
                w_fails_nxt = '0;
`endif
              end else begin
                w_state_nxt = S_FAIL;
`ifdef LOCKOUT_EN
                if (r_fails != 2'd3) w_fails_nxt = r_fails + 2'd1;
`endif
              end
            end
          endcase
        end else if (w_up) begin
          w_number_nxt = c_nw'(r_number[3:0] + 4'd1);
        end else if (w_down) begin
          w_number_nxt = c_nw'(r_number[3:0] - 4'd1);
        end
      end
      S_PASS: begin
        if (w_enter) w_state_nxt = S_LOCKED;
      end
      S_FAIL: begin
        if (r_timer == c_timer_w'(FAIL_HOLD - 1)) begin
          w_timer_nxt = '0;
`ifdef LOCKOUT_EN
          w_state_nxt = (r_fails == 2'd3) ? S_LOCKOUT : S_LOCKED;
`else
          w_state_nxt = S_LOCKED;
`endif
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
`ifdef LOCKOUT_EN
      S_LOCKOUT: begin
        if (r_timer == c_timer_w'(LOCKOUT_CYCLES - 1)) begin
          w_timer_nxt = '0;
          w_fails_nxt = '0;
          w_state_nxt = S_LOCKED;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_LOCKED;
    endcase

    if (w_state_nxt == S_LOCKED) begin
      w_number_nxt = '0;
      w_entry_nxt  = '0;
    end
  end

  assign Select   = c_sw'(r_state);
  assign Number   = r_number;
  assign Unlocked = r_unlocked;

endmodule
`default_nettype wire

// File: tb/tb_combination_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_combination_entry                                            |
// | Purpose  : Directed self-checking bench for combination_entry.             |
// | Options  : LOCKOUT_EN - also exercises the three-fail lockout.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_combination_entry;

  localparam logic [2:0] M_UP  = 3'b001;
  localparam logic [2:0] M_DN  = 3'b010;
  localparam logic [2:0] M_ENT = 3'b100;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       BTN_UP;
  logic       BTN_DOWN;
  logic       BTN_ENTER;
  logic [2:0] Select;
  logic [3:0] Number;
  logic       Unlocked;

  int n_checks = 0;
  int n_fail   = 0;

  combination_entry #(
    .DWL             (8),
    .CODE            (16'h1234),
    .DEBOUNCE_CYCLES (4),
    .FAIL_HOLD       (8),
    .LOCKOUT_CYCLES  (16)
  ) u_dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .BTN_UP    (BTN_UP),
    .BTN_DOWN  (BTN_DOWN),
    .BTN_ENTER (BTN_ENTER),
    .Select    (Select),
    .Number    (Number),
    .Unlocked  (Unlocked)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input logic [2:0] m);
    {BTN_ENTER, BTN_DOWN, BTN_UP} = m;
  endtask

  // Raw high -> pulse after 7 edges, outputs updated on the 8th.
  task automatic press(input logic [2:0] m);
    set_btn(m);
    tick(8);
    set_btn(3'b000);
    tick(8);
  endtask

`ifdef LOCKOUT_EN
  task automatic enter_code(input int a, input int b, input int c, input int d);
    press(M_ENT);
    repeat (a) press(M_UP);
    press(M_ENT);
    repeat (b) press(M_UP);
    press(M_ENT);
    repeat (c) press(M_UP);
    press(M_ENT);
    repeat (d) press(M_UP);
    press(M_ENT);
  endtask
`endif

  initial begin
    RST_N = 1'b0;
    set_btn(3'b000);
    tick(3);
    RST_N = 1'b1;
    tick(1);
    chk("reset_select", Select, 3'b000);
    chk("reset_number", Number, 4'd0);
    chk("reset_unlocked", Unlocked, 1'b0);
    press(M_UP);
    chk("locked_up_number", Number, 4'd0);
    press(M_DN);
    chk("locked_dn_select", Select, 3'b000);
    chk("locked_dn_number", Number, 4'd0);

    // Correct code 1-2-3-4
    press(M_ENT);
    chk("ok_d0", Select, 3'b001);
    press(M_UP);
    chk("ok_num1", Number, 4'd1);
    press(M_ENT);
    chk("ok_d1", Select, 3'b010);
    chk("ok_d1_num", Number, 4'd0);
    repeat (2) press(M_UP);
    press(M_ENT);
    chk("ok_d2", Select, 3'b011);
    repeat (3) press(M_UP);
    press(M_ENT);
    chk("ok_d3", Select, 3'b100);
    repeat (4) press(M_UP);
    chk("ok_num4", Number, 4'd4);
    set_btn(M_ENT);
    tick(7);
    chk("ok_pulse_select", Select, 3'b100);
    chk("ok_pulse_unlocked", Unlocked, 1'b0);
    tick(1);
    chk("ok_pass_select", Select, 3'b110);
    chk("ok_pass_unlocked", Unlocked, 1'b1);
    set_btn(3'b000);
    tick(8);
    press(M_ENT);
    chk("ok_relock_select", Select, 3'b000);
    chk("ok_relock_unlocked", Unlocked, 1'b0);

    // Wrap and bounce
    press(M_ENT);
    press(M_DN);
    chk("wrap_down", Number, 4'd15);
    press(M_UP);
    chk("wrap_up", Number, 4'd0);
    for (int k = 0; k < 10; k++) begin
      BTN_UP = ~BTN_UP;
      tick(2);
    end
    chk("bounce_none", Number, 4'd0);
    BTN_UP = 1'b1;
    tick(7);
    chk("bounce_hold_early", Number, 4'd0);
    tick(1);
    chk("bounce_hold_inc", Number, 4'd1);
    tick(20);
    chk("bounce_hold_single", Number, 4'd1);
    BTN_UP = 1'b0;
    tick(8);

    // Wrong code 1-2-3-5, ENTER re-pressed so its pulse lands in FAIL
    press(M_ENT);
    chk("bad_d1", Select, 3'b010);
    repeat (2) press(M_UP);
    press(M_UP | M_DN);
    chk("up_dn_same_cycle", Number, 4'd2);
    press(M_ENT);
    repeat (3) press(M_UP);
    press(M_ENT);
    repeat (5) press(M_UP);
    chk("bad_num5", Number, 4'd5);
    set_btn(M_ENT);
    tick(4);
    set_btn(3'b000);
    tick(4);
    chk("fail_enter", Select, 3'b111);
    chk("fail_unlocked", Unlocked, 1'b0);
    set_btn(M_ENT);
    tick(7);
    chk("fail_last_cycle", Select, 3'b111);
    tick(1);
    chk("fail_exit_select", Select, 3'b000);
    chk("fail_exit_number", Number, 4'd0);
    tick(4);
    chk("fail_enter_ignored", Select, 3'b000);
    set_btn(3'b000);
    tick(8);
    chk("fail_enter_no_event", Select, 3'b000);

    // Priority: UP+ENTER in D1 latches digit 1 unchanged
    press(M_ENT);
    press(M_UP);
    press(M_ENT);
    repeat (2) press(M_UP);
    press(M_UP | M_ENT);
    chk("prio_select", Select, 3'b011);
    chk("prio_number", Number, 4'd0);
    repeat (3) press(M_UP);
    press(M_ENT);
    repeat (4) press(M_UP);
    press(M_ENT);
    chk("prio_pass", Select, 3'b110);
    chk("prio_unlocked", Unlocked, 1'b1);
    press(M_ENT);

    // Reset mid-entry in D2
    press(M_ENT);
    press(M_ENT);
    press(M_ENT);
    press(M_UP);
    chk("mid_d2", Select, 3'b011);
    RST_N = 1'b0;
    tick(1);
    chk("mid_rst_select", Select, 3'b000);
    chk("mid_rst_number", Number, 4'd0);
    RST_N = 1'b1;
    tick(2);

`ifdef LOCKOUT_EN
    enter_code(0, 0, 0, 0);
    chk("lock_fail1", Select, 3'b000);
    enter_code(0, 0, 0, 0);
    chk("lock_fail2", Select, 3'b000);
    enter_code(0, 0, 0, 0);
    chk("lockout_start", Select, 3'b101);
    tick(15);
    chk("lockout_last", Select, 3'b101);
    tick(1);
    chk("lockout_exit", Select, 3'b000);
    enter_code(1, 2, 3, 4);
    chk("lockout_then_pass", Select, 3'b110);
    chk("lockout_then_unlocked", Unlocked, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
